// File: rtl/seg_display_pkg.sv
// Shared constants and helpers for the seven-segment source selector.
package seg_display_pkg;

  localparam logic [1:0] MODE_STATUS = 2'd0;
  localparam logic [1:0] MODE_COLOR  = 2'd1;
  localparam logic [1:0] MODE_FRAME  = 2'd2;
  localparam logic [1:0] MODE_AUTO   = 2'd3;

  localparam logic [3:0] NIBBLE_F = 4'hF;

  localparam int unsigned MAX_DIGITS = 16;

  // Blank pattern: every nibble F; callers slice the low 4*DIGITS bits.
  function automatic logic [4*MAX_DIGITS-1:0] reset_digits();
    return {MAX_DIGITS{NIBBLE_F}};
  endfunction

endpackage

// File: rtl/seg_tick_divider.sv
// Free-running modulo-DIV counter with a one-cycle tick on its last count.
module seg_tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = !clr && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_display_mux.sv
// Selects status, colour, frame or auto-rotating colour for the digit scan driver;
// also checks frame parity, blinks the fault marker and counts good frames.
module seg_display_mux
  import seg_display_pkg::*;
#(
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned CH_COUNT   = 4,
  parameter int unsigned CH_W       = $clog2(CH_COUNT),
  parameter int unsigned COLOR_W    = 24,
  parameter int unsigned FRAME_W    = 9,
  parameter bit          PARITY_ODD = 1'b1,
  parameter int unsigned BLINK_DIV  = 25_000_000,
  parameter int unsigned ROT_DIV    = 100_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  mode,
  input  logic                        debug_clr_reg,
  input  logic                        fault,
  input  logic [CH_W-1:0]             channel,
  input  logic                        frame_valid,
  input  logic [FRAME_W-1:0]          frame,
  input  logic [CH_COUNT*COLOR_W-1:0] rgb_flat,
  input  logic [CH_COUNT*COLOR_W-1:0] cfg_flat,
  output logic [4*DIGITS-1:0]         digit,
  output logic [DIGITS-1:0]           en_dot,
  output logic [DIGITS-1:0]           en_digit,
  output logic                        frame_err,
  output logic [7:0]                  frame_cnt
);

  localparam int unsigned DW           = FRAME_W - 1;
  localparam int unsigned COLOR_NIB    = COLOR_W / 4;
  localparam int unsigned FIELD_W      = 4 * (DIGITS - 2);
  localparam int unsigned FRAME_DIGITS = (DIGITS < DW) ? DIGITS : DW;
  localparam logic [4*MAX_DIGITS-1:0] RST_ALL = reset_digits();
  localparam logic [4*DIGITS-1:0]     RST_DIGITS = RST_ALL[4*DIGITS-1:0];

  logic blink_tick, rot_tick, rot_clr;
  logic blink_q, blink_d;
  logic [CH_W-1:0] auto_ch_q, auto_ch_d;
  logic [DW-1:0] data_q, data_d;
  logic seen_q, seen_d, err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic frame_good;

  assign rot_clr = (mode != MODE_AUTO);

  seg_tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .tick (blink_tick)
  );

  seg_tick_divider #(.DIV(ROT_DIV)) u_rot_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (rot_clr),
    .tick (rot_tick)
  );

  assign frame_good = ((^frame) == PARITY_ODD);

  always_comb begin
    data_d = data_q;
    seen_d = seen_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    if (frame_valid) begin
      if (frame_good) begin
        data_d = frame[DW-1:0];
        seen_d = 1'b1;
        err_d  = 1'b0;
        cnt_d  = cnt_q + 8'd1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    blink_d   = blink_tick ? !blink_q : blink_q;
    auto_ch_d = auto_ch_q;
    if (rot_clr) begin
      auto_ch_d = '0;
    end else if (rot_tick) begin
      auto_ch_d = (auto_ch_q == CH_W'(CH_COUNT - 1)) ? '0 : auto_ch_q + CH_W'(1);
    end
  end

  logic [CH_W-1:0]     sel_ch;
  logic [COLOR_W-1:0]  sel_word;
  logic [FIELD_W-1:0]  field;
  logic [4*DIGITS-1:0] digit_d;
  logic [DIGITS-1:0]   en_dot_d, en_digit_d;

  always_comb begin
    sel_ch   = (mode == MODE_AUTO) ? auto_ch_q : channel;
    sel_word = '0;
    // Out-of-range channels match no entry and leave the colour field blank.
    for (int k = 0; k < CH_COUNT; k++) begin
      if (sel_ch == CH_W'(k)) begin
        sel_word = debug_clr_reg ? cfg_flat[k*COLOR_W +: COLOR_W]
                                 : rgb_flat[k*COLOR_W +: COLOR_W];
      end
    end
    field = FIELD_W'(sel_word);
  end

  always_comb begin
    digit_d    = '0;
    en_dot_d   = '0;
    en_digit_d = '0;
    case (mode)
      MODE_STATUS: begin
        digit_d[3:0]  = 4'(channel);
        en_digit_d[0] = 1'b1;
        if (fault) begin
          digit_d[4*DIGITS-4 +: 4] = NIBBLE_F;
          en_digit_d[DIGITS-1]     = blink_q;
        end
      end
      MODE_COLOR, MODE_AUTO: begin
        digit_d[3:0]            = 4'(sel_ch);
        digit_d[4*DIGITS-1:8]   = field;
        en_digit_d[0]           = 1'b1;
        for (int i = 0; i < COLOR_NIB; i++) en_digit_d[2+i] = 1'b1;
        en_dot_d[0]             = (mode == MODE_AUTO);
      end
      default: begin
        // Uses next-state frame values so a frame shows on the edge it arrives.
        if (seen_d) begin
          for (int i = 0; i < FRAME_DIGITS; i++) begin
            digit_d[4*i +: 4] = {3'b000, data_d[i]};
            en_digit_d[i]     = 1'b1;
          end
          en_dot_d[DIGITS-1] = err_d;
        end else begin
          digit_d = RST_DIGITS;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q   <= 1'b1;
      auto_ch_q <= '0;
      data_q    <= '0;
      seen_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      digit     <= RST_DIGITS;
      en_dot    <= '0;
      en_digit  <= '0;
    end else begin
      blink_q   <= blink_d;
      auto_ch_q <= auto_ch_d;
      data_q    <= data_d;
      seen_q    <= seen_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      digit     <= digit_d;
      en_dot    <= en_dot_d;
      en_digit  <= en_digit_d;
    end
  end

  assign frame_err = err_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux with short blink/rotate dividers.
module tb_seg_display_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        debug_clr_reg;
  logic        fault;
  logic [1:0]  channel;
  logic        frame_valid;
  logic [8:0]  frame;
  logic [95:0] rgb_flat;
  logic [95:0] cfg_flat;
  logic [31:0] digit;
  logic [7:0]  en_dot;
  logic [7:0]  en_digit;
  logic        frame_err;
  logic [7:0]  frame_cnt;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  seg_display_mux #(
    .BLINK_DIV  (4),
    .ROT_DIV    (8),
    .PARITY_ODD (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mode          (mode),
    .debug_clr_reg (debug_clr_reg),
    .fault         (fault),
    .channel       (channel),
    .frame_valid   (frame_valid),
    .frame         (frame),
    .rgb_flat      (rgb_flat),
    .cfg_flat      (cfg_flat),
    .digit         (digit),
    .en_dot        (en_dot),
    .en_digit      (en_digit),
    .frame_err     (frame_err),
    .frame_cnt     (frame_cnt)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [8:0] f);
    frame       = f;
    frame_valid = 1'b1;
    step(1);
    frame_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digit"}, 64'(digit), 64'hFFFF_FFFF);
    check({tag, "_en_digit"}, 64'(en_digit), 64'h0);
    check({tag, "_en_dot"}, 64'(en_dot), 64'h0);
    check({tag, "_err"}, 64'(frame_err), 64'h0);
    check({tag, "_cnt"}, 64'(frame_cnt), 64'h0);
  endtask

  initial begin
    int waited;
    logic [3:0] exp_nib;
    rst           = 1'b1;
    mode          = 2'd0;
    debug_clr_reg = 1'b0;
    fault         = 1'b0;
    channel       = 2'd2;
    frame_valid   = 1'b0;
    frame         = '0;
    rgb_flat      = {24'h333333, 24'h222222, 24'hABCDEF, 24'h111111};
    cfg_flat      = {24'h0, 24'h0, 24'h123456, 24'h0};

    #1;
    check_reset_outputs("reset");
    #11 rst = 1'b0;
    step(1);

    // STATUS idle
    check("status_digit", 64'(digit), 64'h0000_0002);
    check("status_en_digit", 64'(en_digit), 64'h01);
    check("status_en_dot", 64'(en_dot), 64'h00);

    // STATUS with fault: find the first low blink phase, then 4 low / 4 high / 4 low
    fault  = 1'b1;
    step(1);
    waited = 0;
    while (en_digit[7] !== 1'b0 && waited < 12) begin
      step(1);
      waited++;
    end
    check("blink_found_low", 64'(waited < 12), 64'h1);
    for (int j = 0; j < 12; j++) begin
      check("fault_nibble", 64'(digit[31:28]), 64'hF);
      check("fault_en0", 64'(en_digit[0]), 64'h1);
      check("blink_en7", 64'(en_digit[7]), 64'((j / 4) % 2));
      step(1);
    end
    fault = 1'b0;

    // COLOR
    mode    = 2'd1;
    channel = 2'd1;
    step(1);
    check("color_rgb_digit", 64'(digit), 64'hABCD_EF01);
    check("color_en_digit", 64'(en_digit), 64'hFD);
    check("color_en_dot", 64'(en_dot), 64'h00);
    debug_clr_reg = 1'b1;
    fault         = 1'b1;
    step(1);
    check("color_cfg_digit", 64'(digit), 64'h1234_5601);
    check("color_fault_ignored", 64'(en_digit), 64'hFD);
    fault         = 1'b0;
    debug_clr_reg = 1'b0;

    // FRAME
    mode = 2'd2;
    step(1);
    check("frame_none_digit", 64'(digit), 64'hFFFF_FFFF);
    check("frame_none_en", 64'(en_digit), 64'h00);
    send_frame(9'h1A5);
    check("frame_good_digit", 64'(digit), 64'h1010_0101);
    check("frame_good_en", 64'(en_digit), 64'hFF);
    check("frame_good_cnt", 64'(frame_cnt), 64'd1);
    check("frame_good_err", 64'(frame_err), 64'h0);
    send_frame(9'h0A5);
    check("frame_bad_digit", 64'(digit), 64'h1010_0101);
    check("frame_bad_err", 64'(frame_err), 64'h1);
    check("frame_bad_dot", 64'(en_dot), 64'h80);
    check("frame_bad_cnt", 64'(frame_cnt), 64'd1);
    send_frame(9'h1F0);
    check("frame_clr_digit", 64'(digit), 64'h1111_0000);
    check("frame_clr_err", 64'(frame_err), 64'h0);
    check("frame_clr_dot", 64'(en_dot), 64'h00);
    check("frame_clr_cnt", 64'(frame_cnt), 64'd2);
    send_frame(9'h1F1);
    check("frame_bad2_err", 64'(frame_err), 64'h1);

    // AUTO rotation: channel steps every 8 outputs
    mode = 2'd3;
    step(1);
    for (int j = 0; j < 40; j++) begin
      exp_nib = 4'((j / 8) % 4);
      check("auto_ch", 64'(digit[3:0]), 64'(exp_nib));
      check("auto_dot", 64'(en_dot[0]), 64'h1);
      step(1);
    end
    check("auto_ch1_word", 64'(digit), 64'hABCD_EF01);
    step(9);
    mode    = 2'd1;
    channel = 2'd3;
    step(2);
    check("color_between_auto", 64'(digit[3:0]), 64'h3);
    check("color_between_dot", 64'(en_dot), 64'h00);
    mode = 2'd3;
    step(1);
    for (int j = 0; j < 9; j++) begin
      exp_nib = (j < 8) ? 4'd0 : 4'd1;
      check("auto_restart", 64'(digit[3:0]), 64'(exp_nib));
      step(1);
    end
    check("err_kept_over_modes", 64'(frame_err), 64'h1);

    // Async reset mid-cycle
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    #1 rst = 1'b0;

    // frame_cnt wrap
    mode        = 2'd2;
    frame       = 9'h1A5;
    frame_valid = 1'b1;
    step(255);
    check("cnt_255", 64'(frame_cnt), 64'd255);
    step(1);
    frame_valid = 1'b0;
    check("cnt_wrap", 64'(frame_cnt), 64'd0);
    check("cnt_wrap_err", 64'(frame_err), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
